// File: rtl/hilo_muldiv.sv
// Execute-stage HI/LO unit: single-cycle MULT/MULTU, MTHI/MTLO/MFHI/MFLO, and a
// 32-iteration radix-2 restoring divider for DIV/DIVU that stalls the pipeline.
module hilo_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  alucontrol_e,
  input  logic        valid_e,
  input  logic        flush_e,
  input  logic        e_stall,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        div_stall,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [4:0] MultControl  = 5'b10000;
  localparam logic [4:0] MultuControl = 5'b10001;
  localparam logic [4:0] DivControl   = 5'b10010;
  localparam logic [4:0] DivuControl  = 5'b10011;
  localparam logic [4:0] MthiControl  = 5'b10100;
  localparam logic [4:0] MtloControl  = 5'b10101;
  localparam logic [4:0] MfhiControl  = 5'b10110;
  localparam logic [4:0] MfloControl  = 5'b10111;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d, dz_q, dz_d;

  logic        go, is_div, is_signed, start, fits;
  logic [31:0] abs_a, abs_b, quo_fix, rem_fix;
  logic [32:0] shifted, diff;
  logic [63:0] prod_s, prod_u;

  always_comb begin
    go        = valid_e & ~flush_e & ~e_stall;
    is_div    = (alucontrol_e == DivControl) | (alucontrol_e == DivuControl);
    is_signed = (alucontrol_e == DivControl);
    start     = (state_q == StIdle) & is_div & valid_e & ~flush_e;
    div_stall = start | ((state_q == StBusy) & ~flush_e);
    abs_a     = (is_signed & src_a[31]) ? -src_a : src_a;
    abs_b     = (is_signed & src_b[31]) ? -src_b : src_b;
    // Low 64 bits of the sign-extended product equal the signed product.
    prod_s    = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    prod_u    = {32'b0, src_a} * {32'b0, src_b};
    shifted   = {rem_q, quo_q[31]};
    diff      = shifted - {1'b0, dvsr_q};
    fits      = ~diff[32];
    quo_fix   = q_neg_q ? -quo_q : quo_q;
    rem_fix   = r_neg_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StBusy;
          count_d = 5'd0;
          rem_d   = 32'd0;
          quo_d   = abs_a;
          dvsr_d  = abs_b;
          q_neg_d = is_signed & (src_a[31] ^ src_b[31]);
          r_neg_d = is_signed & src_a[31];
          dz_d    = (src_b == 32'd0);
        end else if (go) begin
          case (alucontrol_e)
            MultControl:  {hi_d, lo_d} = prod_s;
            MultuControl: {hi_d, lo_d} = prod_u;
            MthiControl:  hi_d = src_a;
            MtloControl:  lo_d = src_a;
            default: ;
          endcase
        end
      end
      StBusy: begin
        rem_d   = fits ? diff[31:0] : shifted[31:0];
        quo_d   = {quo_q[30:0], fits};
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) state_d = StDone;
      end
      StDone: begin
        if (!e_stall) begin
          // A zero divisor leaves |a| in the remainder; only LO needs overriding.
          lo_d    = dz_q ? 32'hFFFF_FFFF : quo_fix;
          hi_d    = rem_fix;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush_e) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvsr_q  <= 32'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    if (alucontrol_e == MfhiControl)      hilo_rdata = hi_q;
    else if (alucontrol_e == MfloControl) hilo_rdata = lo_q;
    else                                  hilo_rdata = 32'd0;
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: directed cases plus random operations checked against an
// arithmetic HI/LO model.
module tb_hilo_muldiv;

  localparam logic [4:0] Nop   = 5'b00000;
  localparam logic [4:0] Mult  = 5'b10000;
  localparam logic [4:0] Multu = 5'b10001;
  localparam logic [4:0] Div   = 5'b10010;
  localparam logic [4:0] Divu  = 5'b10011;
  localparam logic [4:0] Mthi  = 5'b10100;
  localparam logic [4:0] Mtlo  = 5'b10101;
  localparam logic [4:0] Mfhi  = 5'b10110;
  localparam logic [4:0] Mflo  = 5'b10111;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  alucontrol_e;
  logic        valid_e, flush_e, e_stall;
  logic [31:0] src_a, src_b;
  logic        div_stall;
  logic [31:0] hilo_rdata, hi_o, lo_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  hilo_muldiv dut (
    .clk          (clk),
    .rst          (rst),
    .alucontrol_e (alucontrol_e),
    .valid_e      (valid_e),
    .flush_e      (flush_e),
    .e_stall      (e_stall),
    .src_a        (src_a),
    .src_b        (src_b),
    .div_stall    (div_stall),
    .hilo_rdata   (hilo_rdata),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alucontrol_e = Nop;
    valid_e      = 1'b0;
    flush_e      = 1'b0;
    e_stall      = 1'b0;
    src_a        = 32'd0;
    src_b        = 32'd0;
  endtask

  task automatic check_hilo(input string tag);
    check({tag, "_hi"}, hi_o, m_hi);
    check({tag, "_lo"}, lo_o, m_lo);
  endtask

  // Reference: architectural meaning of each op using 64-bit arithmetic.
  task automatic model_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (code)
      Mult: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      Multu: begin p = 64'(a) * 64'(b); m_hi = p[63:32]; m_lo = p[31:0]; end
      Mthi: m_hi = a;
      Mtlo: m_lo = a;
      Div, Divu: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else if (code == Div) begin
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    alucontrol_e = code;
    src_a        = a;
    src_b        = b;
    valid_e      = 1'b1;
    #1;
    if (code == Mfhi)      check("mfhi_rdata", hilo_rdata, m_hi);
    else if (code == Mflo) check("mflo_rdata", hilo_rdata, m_lo);
    else                   check("op_rdata_zero", hilo_rdata, 32'd0);
    check("op_no_stall", {31'd0, div_stall}, 32'd0);
    model_op(code, a, b);
    cyc();
    idle_inputs();
    #1;
    check_hilo("op");
  endtask

  task automatic run_div(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
    int n;
    alucontrol_e = code;
    src_a        = a;
    src_b        = b;
    valid_e      = 1'b1;
    #1;
    n = 0;
    while (div_stall === 1'b1 && n < 200) begin
      n++;
      cyc();
    end
    check("div_stall_cycles", 32'(n), 32'd33);
    for (int i = 0; i < hold; i++) begin
      e_stall = 1'b1;
      #1;
      check("done_stall_low", {31'd0, div_stall}, 32'd0);
      cyc();
      check_hilo("done_hold");
    end
    e_stall = 1'b0;
    #1;
    check("done_release_stall", {31'd0, div_stall}, 32'd0);
    model_op(code, a, b);
    cyc();
    idle_inputs();
    #1;
    check_hilo("div");
    check("div_after_stall", {31'd0, div_stall}, 32'd0);
  endtask

  initial begin
    logic [4:0] codes [8];
    logic [4:0] c;
    logic [31:0] a, b;
    codes = '{Mult, Multu, Div, Divu, Mthi, Mtlo, Mfhi, Mflo};

    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_hilo("reset");
      check("reset_stall", {31'd0, div_stall}, 32'd0);
      check("reset_rdata", hilo_rdata, 32'd0);
    end

    run_op(Mult, 32'hFFFF_FFFE, 32'd3);
    check("mult_hi_const", hi_o, 32'hFFFF_FFFF);
    check("mult_lo_const", lo_o, 32'hFFFF_FFFA);
    run_op(Multu, 32'hFFFF_FFFE, 32'd3);
    check("multu_hi_const", hi_o, 32'h0000_0002);
    check("multu_lo_const", lo_o, 32'hFFFF_FFFA);

    run_div(Div, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_neg7_lo", lo_o, 32'hFFFF_FFFD);
    check("div_neg7_hi", hi_o, 32'hFFFF_FFFF);
    run_div(Divu, 32'd100, 32'd7, 0);
    check("divu_100_7_lo", lo_o, 32'd14);
    check("divu_100_7_hi", hi_o, 32'd2);
    run_div(Div, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf_lo", lo_o, 32'h8000_0000);
    check("div_ovf_hi", hi_o, 32'd0);
    run_div(Divu, 32'd5, 32'd0, 0);
    check("divu_zero_lo", lo_o, 32'hFFFF_FFFF);
    check("divu_zero_hi", hi_o, 32'd5);

    // Flush part-way through a division.
    run_op(Mthi, 32'h11, 32'd0);
    run_op(Mtlo, 32'h22, 32'd0);
    alucontrol_e = Divu;
    src_a        = 32'd50;
    src_b        = 32'd3;
    valid_e      = 1'b1;
    #1;
    check("flush_start_stall", {31'd0, div_stall}, 32'd1);
    for (int i = 0; i < 10; i++) cyc();
    check("flush_busy_stall", {31'd0, div_stall}, 32'd1);
    flush_e = 1'b1;
    #1;
    check("flush_stall_drop", {31'd0, div_stall}, 32'd0);
    cyc();
    idle_inputs();
    #1;
    check("flush_idle_stall", {31'd0, div_stall}, 32'd0);
    check("flush_keep_hi", hi_o, 32'h11);
    check("flush_keep_lo", lo_o, 32'h22);
    for (int i = 0; i < 40; i++) cyc();
    check_hilo("flush_later");
    run_div(Divu, 32'd9, 32'd4, 0);
    check("divu_9_4_lo", lo_o, 32'd2);
    check("divu_9_4_hi", hi_o, 32'd1);

    run_op(Mthi, 32'h33, 32'd0);
    run_div(Divu, 32'd9, 32'd4, 3);
    check("divu_hold_lo", lo_o, 32'd2);
    check("divu_hold_hi", hi_o, 32'd1);
    run_op(Mthi, 32'hABCD, 32'd0);
    alucontrol_e = Mfhi;
    valid_e      = 1'b1;
    #1;
    check("mfhi_after_mthi", hilo_rdata, 32'hABCD);
    cyc();
    idle_inputs();

    // Reset in the middle of a division.
    alucontrol_e = Div;
    src_a        = 32'd1000;
    src_b        = 32'd7;
    valid_e      = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    rst = 1'b1;
    idle_inputs();
    cyc();
    rst = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    check_hilo("midreset");
    check("midreset_stall", {31'd0, div_stall}, 32'd0);
    cyc();
    check_hilo("midreset_later");

    for (int i = 0; i < 40; i++) begin
      c = codes[$urandom_range(7, 0)];
      a = $urandom();
      b = $urandom();
      case ($urandom_range(7, 0))
        0: b = 32'd0;
        1: b = 32'($urandom_range(9, 1));
        2: a = 32'h8000_0000;
        default: ;
      endcase
      if (c == Div || c == Divu) run_div(c, a, b, $urandom_range(2, 0));
      else                       run_op(c, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
